wino_ewmul_accum: RTL and testbench

//  Downstream consumer of the Winograd input-transform stage. Takes up to two transformed
//  6x6 input tiles per cycle and multiplies each element-wise by the resident transformed

---
 rtl/winocnn_pkg.sv | 16 +
 rtl/wino_ewmul.sv | 39 +++
 rtl/wino_ewmul_accum.sv | 161 ++++++++++++++++
 tb/tb_wino_ewmul_accum.sv | 319 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/winocnn_pkg.sv
// Shared constants and tile types for the Winograd element-wise multiply and
// accumulate stage.
//   TILE         : transformed tile edge (6x6 elements)
//   IN_W         : signed width of transformed input elements
//   INVALID_ADDR : address tag marking an empty lane
//   in_tile_t    : one transformed input tile
//   acc_tile_t   : one accumulated tile at the default accumulator width
package winocnn_pkg;
    localparam int         TILE         = 6;
    localparam int         IN_W         = 14;
    localparam int         ACC_W_DEF    = 32;
    localparam logic [7:0] INVALID_ADDR = 8'hFF;

    typedef logic [TILE-1:0][TILE-1:0][IN_W-1:0]      in_tile_t;
    typedef logic [TILE-1:0][TILE-1:0][ACC_W_DEF-1:0] acc_tile_t;
endpackage

// File: rtl/wino_ewmul.sv
// One lane of the element-wise multiply: 36 registered signed products of a
// transformed input tile and the resident transformed weight tile.
//   clk, reset : clock, asynchronous active-high reset
//   tile_i     : transformed input tile (signed IN_W elements)
//   weight_i   : transformed weight tile (signed WGT_W elements)
//   prod_o     : registered full-precision products (IN_W+WGT_W bits)
module wino_ewmul
    import winocnn_pkg::*;
#(
    parameter int WGT_W = 16
) (
    input  logic                                     clk,
    input  logic                                     reset,
    input  in_tile_t                                 tile_i,
    input  logic [TILE-1:0][TILE-1:0][WGT_W-1:0]     weight_i,
    output logic [TILE-1:0][TILE-1:0][IN_W+WGT_W-1:0] prod_o
);
    localparam int PW = IN_W + WGT_W;

    logic [TILE-1:0][TILE-1:0][PW-1:0] prod_d, prod_q;

    // Operands are sign-extended to the full product width so the product
    // is exact and never truncated.
    always_comb begin
        prod_d = '0;
        for (int r = 0; r < TILE; r++) begin
            for (int c = 0; c < TILE; c++) begin
                prod_d[r][c] = PW'($signed(tile_i[r][c])) * PW'($signed(weight_i[r][c]));
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) prod_q <= '0;
        else       prod_q <= prod_d;
    end

    assign prod_o = prod_q;
endmodule

// File: rtl/wino_ewmul_accum.sv
// Winograd element-wise multiply and cross-channel accumulate.
// Two lanes per cycle; each valid tile is multiplied by the resident weight
// tile (S1), then added into its addressed accumulator entry (S2). On the last
// channel the sum is emitted two cycles after the input.
//   clk, reset              : clock, asynchronous active-high reset
//   weight_tile_i/valid_i   : weight tile load (takes effect at the edge)
//   tile_i_1/_2, addr_i_1/_2: input tiles and accumulator addresses per lane
//   data_valid_i            : inputs valid this cycle
//   size_type_i             : kernel size tag, delayed to match outputs
//   first_ch_i, last_ch_i   : channel 0 (overwrite) / final channel (emit)
//   acc_tile_o_*, acc_addr_o_*, acc_valid_o_* : emitted sums per lane
//   size_type_o             : size tag aligned to emitted sums
//   busy_o                  : any pipeline stage holds a valid lane
//   err_o                   : sticky flag for dropped lanes
module wino_ewmul_accum
    import winocnn_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int WGT_W = 16,
    parameter int ACC_W = 32
) (
    input  logic                                  clk,
    input  logic                                  reset,
    input  logic [TILE-1:0][TILE-1:0][WGT_W-1:0]  weight_tile_i,
    input  logic                                  weight_valid_i,
    input  in_tile_t                              tile_i_1,
    input  in_tile_t                              tile_i_2,
    input  logic [7:0]                            addr_i_1,
    input  logic [7:0]                            addr_i_2,
    input  logic                                  data_valid_i,
    input  logic                                  size_type_i,
    input  logic                                  first_ch_i,
    input  logic                                  last_ch_i,
    output logic [TILE-1:0][TILE-1:0][ACC_W-1:0]  acc_tile_o_1,
    output logic [TILE-1:0][TILE-1:0][ACC_W-1:0]  acc_tile_o_2,
    output logic [7:0]                            acc_addr_o_1,
    output logic [7:0]                            acc_addr_o_2,
    output logic                                  acc_valid_o_1,
    output logic                                  acc_valid_o_2,
    output logic                                  size_type_o,
    output logic                                  busy_o,
    output logic                                  err_o
);
    localparam int         PW      = IN_W + WGT_W;
    localparam int         AW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [8:0] DEPTH_L = 9'(DEPTH);

    typedef logic [TILE-1:0][TILE-1:0][WGT_W-1:0] wgt_tile_t;
    typedef logic [TILE-1:0][TILE-1:0][PW-1:0]    prod_tile_t;
    typedef logic [TILE-1:0][TILE-1:0][ACC_W-1:0] sum_tile_t;

    wgt_tile_t              weight_d, weight_q;
    logic                   err_d, err_q;
    logic [1:0]             s1_vld_d, s1_vld_q, s2_vld_q;
    logic [1:0][7:0]        s1_addr_d, s1_addr_q;
    logic                   s1_first_q, s1_last_q, s1_size_q, size_q;
    sum_tile_t [DEPTH-1:0]  buf_d, buf_q;
    sum_tile_t [1:0]        sum, acc_tile_d, acc_tile_q;
    logic [1:0][7:0]        acc_addr_d, acc_addr_q;
    logic [1:0]             acc_valid_d, acc_valid_q;
    in_tile_t               lane_tile [2];
    prod_tile_t             prod [2];
    logic [1:0]             in_rng, bad;
    logic                   collide;

    assign lane_tile[0] = tile_i_1;
    assign lane_tile[1] = tile_i_2;

    for (genvar k = 0; k < 2; k++) begin : g_lane
        wino_ewmul #(.WGT_W(WGT_W)) u_mul (
            .clk      (clk),
            .reset    (reset),
            .tile_i   (lane_tile[k]),
            .weight_i (weight_q),
            .prod_o   (prod[k])
        );
    end

    // Lane qualification. A same-address pair would race on one buffer
    // entry in S2, so lane 2 yields to lane 1.
    always_comb begin
        in_rng[0] = (addr_i_1 != INVALID_ADDR) && ({1'b0, addr_i_1} < DEPTH_L);
        in_rng[1] = (addr_i_2 != INVALID_ADDR) && ({1'b0, addr_i_2} < DEPTH_L);
        bad[0]    = (addr_i_1 != INVALID_ADDR) && !in_rng[0];
        bad[1]    = (addr_i_2 != INVALID_ADDR) && !in_rng[1];
        collide   = data_valid_i && in_rng[0] && in_rng[1] && (addr_i_1 == addr_i_2);
        s1_vld_d  = {data_valid_i && in_rng[1] && !collide, data_valid_i && in_rng[0]};
        s1_addr_d = {addr_i_2, addr_i_1};
        err_d     = err_q || (data_valid_i && (bad[0] || bad[1])) || collide;
        weight_d  = weight_valid_i ? weight_tile_i : weight_q;
    end

    // S2: read-modify-write of the accumulator. Writes from the previous edge
    // are already in buf_q, so consecutive same-address passes chain without
    // forwarding; the two lanes never share an address.
    always_comb begin
        buf_d       = buf_q;
        sum         = '0;
        acc_tile_d  = '0;
        acc_addr_d  = '0;
        acc_valid_d = '0;
        for (int k = 0; k < 2; k++) begin
            if (s1_vld_q[k]) begin
                for (int r = 0; r < TILE; r++) begin
                    for (int c = 0; c < TILE; c++) begin
                        sum[k][r][c] = (s1_first_q ? '0 : buf_q[s1_addr_q[k][AW-1:0]][r][c])
                                     + ACC_W'($signed(prod[k][r][c]));
                    end
                end
                buf_d[s1_addr_q[k][AW-1:0]] = sum[k];
                if (s1_last_q) begin
                    acc_tile_d[k]  = sum[k];
                    acc_addr_d[k]  = s1_addr_q[k];
                    acc_valid_d[k] = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            weight_q    <= '0;
            err_q       <= 1'b0;
            s1_vld_q    <= '0;
            s1_addr_q   <= '0;
            s1_first_q  <= 1'b0;
            s1_last_q   <= 1'b0;
            s1_size_q   <= 1'b0;
            s2_vld_q    <= '0;
            size_q      <= 1'b0;
            buf_q       <= '0;
            acc_tile_q  <= '0;
            acc_addr_q  <= '0;
            acc_valid_q <= '0;
        end else begin
            weight_q    <= weight_d;
            err_q       <= err_d;
            s1_vld_q    <= s1_vld_d;
            s1_addr_q   <= s1_addr_d;
            s1_first_q  <= first_ch_i;
            s1_last_q   <= last_ch_i;
            s1_size_q   <= size_type_i;
            s2_vld_q    <= s1_vld_q;
            size_q      <= s1_size_q;
            buf_q       <= buf_d;
            acc_tile_q  <= acc_tile_d;
            acc_addr_q  <= acc_addr_d;
            acc_valid_q <= acc_valid_d;
        end
    end

    assign acc_tile_o_1  = acc_tile_q[0];
    assign acc_tile_o_2  = acc_tile_q[1];
    assign acc_addr_o_1  = acc_addr_q[0];
    assign acc_addr_o_2  = acc_addr_q[1];
    assign acc_valid_o_1 = acc_valid_q[0];
    assign acc_valid_o_2 = acc_valid_q[1];
    assign size_type_o   = size_q;
    assign busy_o        = (|s1_vld_q) || (|s2_vld_q);
    assign err_o         = err_q;
endmodule

// File: tb/tb_wino_ewmul_accum.sv
// Self-checking bench for wino_ewmul_accum: directed table, hand-written
// multi-cycle sequences, and a randomized run against a cycle-slot model.
module tb_wino_ewmul_accum;
    import winocnn_pkg::*;

    localparam int DEPTH = 16;
    localparam int WGT_W = 16;
    localparam int ACC_W = 32;
    localparam int NE    = TILE * TILE;

    typedef logic [TILE-1:0][TILE-1:0][WGT_W-1:0] w_tile_t;

    logic      clk = 1'b0;
    logic      reset;
    w_tile_t   weight_tile_i;
    logic      weight_valid_i;
    in_tile_t  tile_i_1, tile_i_2;
    logic [7:0] addr_i_1, addr_i_2;
    logic      data_valid_i, size_type_i, first_ch_i, last_ch_i;
    acc_tile_t acc_tile_o_1, acc_tile_o_2;
    logic [7:0] acc_addr_o_1, acc_addr_o_2;
    logic      acc_valid_o_1, acc_valid_o_2, size_type_o, busy_o, err_o;

    wino_ewmul_accum #(.DEPTH(DEPTH), .WGT_W(WGT_W), .ACC_W(ACC_W)) dut (
        .clk(clk), .reset(reset),
        .weight_tile_i(weight_tile_i), .weight_valid_i(weight_valid_i),
        .tile_i_1(tile_i_1), .tile_i_2(tile_i_2),
        .addr_i_1(addr_i_1), .addr_i_2(addr_i_2),
        .data_valid_i(data_valid_i), .size_type_i(size_type_i),
        .first_ch_i(first_ch_i), .last_ch_i(last_ch_i),
        .acc_tile_o_1(acc_tile_o_1), .acc_tile_o_2(acc_tile_o_2),
        .acc_addr_o_1(acc_addr_o_1), .acc_addr_o_2(acc_addr_o_2),
        .acc_valid_o_1(acc_valid_o_1), .acc_valid_o_2(acc_valid_o_2),
        .size_type_o(size_type_o), .busy_o(busy_o), .err_o(err_o)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int errors = 0;
    int checks = 0;

    // Reference model: plain integer arrays; expected outputs are filed into a
    // ring of future-cycle slots indexed by cycle number.
    int m_w [NE];
    int m_buf [DEPTH][NE];
    bit m_err;
    bit ex_v [4][2];
    int ex_a [4][2];
    int ex_t [4][2][NE];
    bit ex_sz [4], ex_busy [4], ex_err [4];

    task automatic chk(input string nm, input longint act, input longint exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s @cyc %0d: got %0d expected %0d", nm, cyc, act, exp);
        end
    endtask

    function automatic in_tile_t fill_in(input int v);
        in_tile_t t;
        for (int e = 0; e < NE; e++) t[e/TILE][e%TILE] = 14'(v);
        return t;
    endfunction

    function automatic w_tile_t fill_w(input int v);
        w_tile_t t;
        for (int e = 0; e < NE; e++) t[e/TILE][e%TILE] = 16'(v);
        return t;
    endfunction

    function automatic in_tile_t rnd_in();
        in_tile_t t;
        for (int e = 0; e < NE; e++) t[e/TILE][e%TILE] = 14'($urandom);
        return t;
    endfunction

    function automatic w_tile_t rnd_w();
        w_tile_t t;
        for (int e = 0; e < NE; e++) t[e/TILE][e%TILE] = 16'($urandom);
        return t;
    endfunction

    task automatic clear_model();
        m_err = 0;
        for (int e = 0; e < NE; e++) m_w[e] = 0;
        for (int a = 0; a < DEPTH; a++) for (int e = 0; e < NE; e++) m_buf[a][e] = 0;
        for (int s = 0; s < 4; s++) begin
            ex_sz[s] = 0; ex_busy[s] = 0; ex_err[s] = 0;
            for (int k = 0; k < 2; k++) begin
                ex_v[s][k] = 0; ex_a[s][k] = 0;
                for (int e = 0; e < NE; e++) ex_t[s][k][e] = 0;
            end
        end
    endtask

    task automatic check_outputs();
        int s;
        s = cyc % 4;
        for (int k = 0; k < 2; k++) begin
            bit       v;
            int       a, got, exp, bad_e;
            acc_tile_t t;
            v = (k == 0) ? acc_valid_o_1 : acc_valid_o_2;
            a = (k == 0) ? acc_addr_o_1 : acc_addr_o_2;
            t = (k == 0) ? acc_tile_o_1 : acc_tile_o_2;
            chk($sformatf("mon valid%0d", k + 1), v, ex_v[s][k]);
            chk($sformatf("mon addr%0d", k + 1), a, ex_a[s][k]);
            bad_e = -1; got = 0; exp = 0;
            for (int e = 0; e < NE; e++) begin
                if (bad_e < 0 && int'($signed(t[e/TILE][e%TILE])) != ex_t[s][k][e]) begin
                    bad_e = e;
                    got   = int'($signed(t[e/TILE][e%TILE]));
                    exp   = ex_t[s][k][e];
                end
            end
            checks++;
            if (bad_e >= 0) begin
                errors++;
                $display("FAIL mon tile%0d elem %0d @cyc %0d: got %0d expected %0d",
                         k + 1, bad_e, cyc, got, exp);
            end
        end
        chk("mon size_type", size_type_o, ex_sz[s]);
        chk("mon busy", busy_o, ex_busy[s]);
        chk("mon err", err_o, ex_err[s]);
    endtask

    // Drives one cycle. Outputs of the current cycle are checked first; the
    // model then files the expected results for this cycle's inputs.
    task automatic step(input bit dv, input int a1, input int a2,
                        input in_tile_t t1, input in_tile_t t2,
                        input bit fi, input bit la, input bit sz,
                        input bit wv, input w_tile_t wt);
        int  s1, s2;
        bit  in1, in2, act [2], col;
        check_outputs();
        data_valid_i = dv; addr_i_1 = 8'(a1); addr_i_2 = 8'(a2);
        tile_i_1 = t1; tile_i_2 = t2;
        first_ch_i = fi; last_ch_i = la; size_type_i = sz;
        weight_valid_i = wv; weight_tile_i = wt;

        s1 = (cyc + 1) % 4;
        s2 = (cyc + 2) % 4;
        for (int k = 0; k < 2; k++) begin
            ex_v[s2][k] = 0; ex_a[s2][k] = 0;
            for (int e = 0; e < NE; e++) ex_t[s2][k][e] = 0;
        end
        in1    = (a1 != 255) && (a1 < DEPTH);
        in2    = (a2 != 255) && (a2 < DEPTH);
        col    = dv && in1 && in2 && (a1 == a2);
        act[0] = dv && in1;
        act[1] = dv && in2 && !col;
        for (int k = 0; k < 2; k++) begin
            if (act[k]) begin
                int a;
                in_tile_t t;
                a = (k == 0) ? a1 : a2;
                t = (k == 0) ? t1 : t2;
                for (int e = 0; e < NE; e++) begin
                    int p;
                    p = int'($signed(t[e/TILE][e%TILE])) * m_w[e];
                    m_buf[a][e] = (fi ? 0 : m_buf[a][e]) + p;
                    if (la) ex_t[s2][k][e] = m_buf[a][e];
                end
                if (la) begin
                    ex_v[s2][k] = 1;
                    ex_a[s2][k] = a;
                end
            end
        end
        ex_sz[s2]   = sz;
        ex_busy[s2] = act[0] || act[1];
        ex_busy[s1] = ex_busy[s1] || act[0] || act[1];
        if (dv && ((a1 != 255 && !in1) || (a2 != 255 && !in2) || col)) m_err = 1;
        ex_err[s1] = m_err;
        if (wv) for (int e = 0; e < NE; e++) m_w[e] = int'($signed(wt[e/TILE][e%TILE]));
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 255, 255, '0, '0, 0, 0, 0, 0, '0);
    endtask

    task automatic load_w(input int v);
        step(0, 255, 255, '0, '0, 0, 0, 0, 1, fill_w(v));
    endtask

    task automatic one(input int a1, input int a2, input int v1, input int v2,
                       input bit fi, input bit la);
        step(1, a1, a2, fill_in(v1), fill_in(v2), fi, la, 0, 0, '0);
    endtask

    task automatic do_reset();
        reset = 1;
        data_valid_i = 0; weight_valid_i = 0; addr_i_1 = 8'hFF; addr_i_2 = 8'hFF;
        clear_model();
        #1;
        check_outputs();
        @(posedge clk);
        #1;
        reset = 0;
    endtask

    typedef struct {
        int w; int a1; int a2; int t1; int t2; bit fi; bit la;
        bit ev1; bit ev2; int ee1; int ee2; bit eerr;
    } vec_t;
    vec_t tbl [6];

    initial begin
        tbl[0] = '{2, 3, 255, 5, 0, 1, 1, 1, 0, 10, 0, 0};
        tbl[1] = '{2, 4, 255, 3, 0, 1, 1, 1, 0, 6, 0, 0};
        tbl[2] = '{-1, 255, 5, 0, -4, 1, 1, 0, 1, 0, 4, 0};
        tbl[3] = '{3, 7, 8, 2, -5, 1, 1, 1, 1, 6, -15, 0};
        tbl[4] = '{2, 10, 255, 4, 0, 1, 0, 0, 0, 0, 0, 0};
        tbl[5] = '{2, 6, 6, 1, 9, 1, 1, 1, 0, 2, 0, 1};

        reset = 1;
        weight_tile_i = '0; weight_valid_i = 0; tile_i_1 = '0; tile_i_2 = '0;
        addr_i_1 = 8'hFF; addr_i_2 = 8'hFF; data_valid_i = 0;
        size_type_i = 0; first_ch_i = 0; last_ch_i = 0;
        clear_model();
        repeat (2) @(posedge clk);
        #1;
        chk("reset valid1", acc_valid_o_1, 0);
        chk("reset busy", busy_o, 0);
        chk("reset err", err_o, 0);
        reset = 0;

        // Directed table: one transaction each, checked at the emit cycle.
        for (int i = 0; i < 6; i++) begin
            load_w(tbl[i].w);
            one(tbl[i].a1, tbl[i].a2, tbl[i].t1, tbl[i].t2, tbl[i].fi, tbl[i].la);
            idle(1);
            chk($sformatf("tbl%0d valid1", i), acc_valid_o_1, tbl[i].ev1);
            chk($sformatf("tbl%0d valid2", i), acc_valid_o_2, tbl[i].ev2);
            if (tbl[i].ev1) begin
                chk($sformatf("tbl%0d addr1", i), acc_addr_o_1, tbl[i].a1);
                chk($sformatf("tbl%0d e1[0][0]", i), int'($signed(acc_tile_o_1[0][0])), tbl[i].ee1);
                chk($sformatf("tbl%0d e1[5][5]", i), int'($signed(acc_tile_o_1[5][5])), tbl[i].ee1);
            end
            if (tbl[i].ev2) begin
                chk($sformatf("tbl%0d addr2", i), acc_addr_o_2, tbl[i].a2);
                chk($sformatf("tbl%0d e2[3][2]", i), int'($signed(acc_tile_o_2[3][2])), tbl[i].ee2);
            end
            chk($sformatf("tbl%0d err", i), err_o, tbl[i].eerr);
        end
        idle(3);
        chk("collision err held", err_o, 1);

        // Out-of-range address is dropped and flags an error.
        do_reset();
        load_w(2);
        one(20, 255, 1, 0, 1, 1);
        chk("range err", err_o, 1);
        idle(1);
        chk("range no emit", acc_valid_o_1, 0);

        // Three channels into one address; only the last one emits.
        do_reset();
        load_w(-3);
        one(0, 255, 1, 0, 1, 0);
        one(0, 255, 1, 0, 0, 0);
        chk("ch0 no emit", acc_valid_o_1, 0);
        one(0, 255, 1, 0, 0, 1);
        chk("ch1 no emit", acc_valid_o_1, 0);
        idle(1);
        chk("ch2 emit", acc_valid_o_1, 1);
        chk("ch2 sum", int'($signed(acc_tile_o_1[2][4])), -9);

        // Weight load in the same cycle as data: that data sees the old weights.
        load_w(1);
        step(1, 2, 255, fill_in(1), '0, 1, 1, 0, 1, fill_w(7));
        one(2, 255, 1, 0, 1, 1);
        chk("old weight", int'($signed(acc_tile_o_1[1][1])), 1);
        idle(1);
        chk("new weight", int'($signed(acc_tile_o_1[1][1])), 7);

        // Reset while a tile sits in S1: no emit, and the buffer restarts at 0.
        do_reset();
        load_w(2);
        one(9, 255, 1, 0, 1, 0);
        idle(2);
        one(9, 255, 1, 0, 0, 1);
        do_reset();
        chk("reset drops emit", acc_valid_o_1, 0);
        load_w(2);
        one(9, 255, 1, 0, 0, 1);
        idle(1);
        chk("post-reset valid", acc_valid_o_1, 1);
        chk("post-reset sum", int'($signed(acc_tile_o_1[0][0])), 2);

        // Randomized traffic checked cycle-by-cycle against the model.
        do_reset();
        load_w(1);
        for (int i = 0; i < 400; i++) begin
            int a [2];
            for (int k = 0; k < 2; k++) begin
                int r;
                r = $urandom_range(0, 9);
                if (r < 7)       a[k] = $urandom_range(0, 5);
                else if (r == 7) a[k] = 255;
                else             a[k] = $urandom_range(DEPTH, 40);
            end
            step($urandom_range(0, 9) < 8, a[0], a[1], rnd_in(), rnd_in(),
                 $urandom_range(0, 2) == 0, $urandom_range(0, 1) == 1,
                 $urandom_range(0, 1) == 1, $urandom_range(0, 9) == 0, rnd_w());
        end
        idle(3);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
